// File: rtl/pwm_serializer.sv
// Fixed-frequency PWM generator: percentage duty word (0..100) to a one-bit PWM output.
// Optional macro PWM_STROBE_EN adds the period_start output (first cycle of each period).
module pwm_serializer #(
   parameter int unsigned SYS_FREQ_HZ   = 100_000_000,
   parameter int unsigned PULSE_FREQ_HZ = 1_000_000,
   parameter int unsigned DUTY_W        = 7
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DUTY_W-1:0] duty_cycle,
   output logic              signal
`ifdef PWM_STROBE_EN
   ,
   output logic              period_start
`endif
);

   localparam int unsigned PERIOD   = SYS_FREQ_HZ / PULSE_FREQ_HZ;
   localparam int unsigned CNT_W    = $clog2(PERIOD);
   localparam int unsigned THR_W    = $clog2(PERIOD + 1);
   localparam int unsigned PROD_W   = DUTY_W + THR_W;
   localparam int unsigned MAX_DUTY = 100;

   if (PERIOD < 2) begin : g_period_check
      $error("pwm_serializer: SYS_FREQ_HZ / PULSE_FREQ_HZ must be at least 2");
   end

   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [THR_W-1:0]  thr_q, thr_d;
   logic              signal_q, signal_d;
   logic              wrap_c;
   logic [PROD_W-1:0] duty_ext;
   logic [PROD_W-1:0] prod;
   logic [THR_W-1:0]  thr_target;

   assign wrap_c = (cnt_q == CNT_W'(PERIOD - 1));

   // Clamped duty scaled to counter cycles; only consumed on the wrap edge.
   always_comb begin
      duty_ext = PROD_W'(duty_cycle);
      if (duty_ext > PROD_W'(MAX_DUTY)) begin
         duty_ext = PROD_W'(MAX_DUTY);
      end
      prod       = duty_ext * PROD_W'(PERIOD);
      thr_target = THR_W'(prod / PROD_W'(MAX_DUTY));
   end

   // Next-state: counter wraps, threshold reloads at the wrap, output follows next values.
   always_comb begin
      cnt_d    = cnt_q + CNT_W'(1);
      thr_d    = thr_q;
      if (wrap_c) begin
         cnt_d = '0;
         thr_d = thr_target;
      end
      signal_d = (THR_W'(cnt_d) < thr_d);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q    <= '0;
         thr_q    <= '0;
         signal_q <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         thr_q    <= thr_d;
         signal_q <= signal_d;
      end
   end

   assign signal = signal_q;

`ifdef PWM_STROBE_EN
   logic strobe_q;
   logic strobe_d;

   assign strobe_d = (cnt_d == '0);

   // Reset loads cnt==0, so the strobe flop presets high; the reset input masks it while asserted.
   always_ff @(posedge clk) begin
      if (reset) begin
         strobe_q <= 1'b1;
      end else begin
         strobe_q <= strobe_d;
      end
   end

   assign period_start = strobe_q & ~reset;
`endif

endmodule

// File: tb/tb_pwm_serializer.sv
// Directed self-checking bench for pwm_serializer (default 100-cycle period).
// Period-level checks count high cycles and verify the high time is a prefix of the period.
`timescale 1ns/1ps
module tb_pwm_serializer;

   logic       clk;
   logic       reset;
   logic [6:0] duty;
   logic       signal;
`ifdef PWM_STROBE_EN
   logic       period_start;
`endif

   int n_checks;
   int n_fail;

   pwm_serializer dut (
      .clk        (clk),
      .reset      (reset),
      .duty_cycle (duty),
      .signal     (signal)
`ifdef PWM_STROBE_EN
      ,
      .period_start (period_start)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Called at the negedge inside a cnt==0 cycle; returns at the negedge of the next cnt==0 cycle.
   // Optionally changes duty at index chg_idx (before that cycle's sample).
   task automatic run_period(input string tag, input int exp_highs,
                             input int chg_idx, input logic [6:0] chg_val);
      int   highs;
      logic prefix_ok;
      logic strobe_ok;
      highs     = 0;
      prefix_ok = 1'b1;
      strobe_ok = 1'b1;
      for (int i = 0; i < 100; i++) begin
         if (i == chg_idx) duty = chg_val;
         if (signal === 1'b1) begin
            if (i != highs) prefix_ok = 1'b0;
            highs++;
         end else if (signal !== 1'b0) begin
            prefix_ok = 1'b0;
         end
`ifdef PWM_STROBE_EN
         if (period_start !== (i == 0)) strobe_ok = 1'b0;
`endif
         @(negedge clk);
      end
      check({tag, ".highs"}, 32'(highs), 32'(exp_highs));
      check({tag, ".shape"}, 32'(prefix_ok), 32'd1);
`ifdef PWM_STROBE_EN
      check({tag, ".strobe"}, 32'(strobe_ok), 32'd1);
`endif
   endtask

   // Holds reset for n edges with the given duty, checks reset state, releases in a cnt==0 cycle.
   task automatic do_reset(input string tag, input logic [6:0] d, input int n);
      reset = 1'b1;
      duty  = d;
      repeat (n) @(negedge clk);
      check({tag, ".rst_signal"}, 32'(signal), 32'd0);
`ifdef PWM_STROBE_EN
      check({tag, ".rst_strobe"}, 32'(period_start), 32'd0);
`endif
      reset = 1'b0;
      #1;
   endtask

   initial begin
      int highs;
      n_checks = 0;
      n_fail   = 0;
      reset    = 1'b1;
      duty     = '0;

      // Duty 50 held through reset: first period low, then 50/50.
      do_reset("t1", 7'd50, 5);
      run_period("t1.p0", 0,  -1, 7'd0);
      run_period("t1.p1", 50, -1, 7'd0);
      run_period("t1.p2", 50, -1, 7'd0);
      run_period("t1.p3", 50, -1, 7'd0);

      // Duty 0 then 100: low periods, then 300 continuous high cycles.
      do_reset("t2", 7'd0, 3);
      run_period("t2.p0", 0,   -1, 7'd0);
      run_period("t2.p1", 0,   0,  7'd100);
      run_period("t2.p2", 100, -1, 7'd0);
      run_period("t2.p3", 100, -1, 7'd0);
      run_period("t2.p4", 100, -1, 7'd0);

      // Duty 25 then 37 changed at cnt=10: current period keeps 25, next gets 37.
      run_period("t3.p0", 100, 0,  7'd25);
      run_period("t3.p1", 25,  10, 7'd37);
      run_period("t3.p2", 37,  -1, 7'd0);

      // Duty 120 clamps to 100.
      run_period("t4.p0", 37,  0,  7'd120);
      run_period("t4.p1", 100, -1, 7'd0);
      run_period("t4.p2", 100, 0,  7'd80);

      // Duty 80 period interrupted by reset at cnt=60.
      highs = 0;
      for (int i = 0; i < 60; i++) begin
         if (signal === 1'b1) highs++;
         @(negedge clk);
      end
      check("t5.partial_highs", 32'(highs), 32'd60);
      check("t5.cnt60_signal", 32'(signal), 32'd1);
      reset = 1'b1;
      #1;
`ifdef PWM_STROBE_EN
      check("t5.rst_edge_strobe", 32'(period_start), 32'd0);
`endif
      @(negedge clk);
      check("t5.after_rst_signal", 32'(signal), 32'd0);
`ifdef PWM_STROBE_EN
      check("t5.in_rst_strobe", 32'(period_start), 32'd0);
`endif
      reset = 1'b0;
      #1;
      run_period("t5.p0", 0,  -1, 7'd0);
      run_period("t5.p1", 80, -1, 7'd0);
      run_period("t5.p2", 80, 0,  7'd1);
      run_period("t5.p3", 1,  -1, 7'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
